divider_seq_qr: RTL and testbench

- Parametrised multi-cycle radix-2 restoring divider; next generation of the team's successive-approximation divider core.
- Needs no external multiplier; produces one quotient bit per clock.
- Returns quotient and remainder, flags divide-by-zero and signed overflow, and supports an unsigned or signed (truncating) mode.
- Sits in the same datapaths (normalisation, ratio and centroid computation); drop-in with a start/qv handshake plus a busy output.

---
 rtl/divider_seq_qr.sv | 126 ++++++++++++
 tb/tb_divider_seq_qr.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq_qr.sv
// Radix-2 restoring divider: one quotient bit per clock, quotient/remainder with dbz/ovf flags.
// Latency DIVIDEND_W+2 clocks start-to-qv; start is ignored while busy, accepted again in the qv cycle.
module divider_seq_qr #(
    parameter int DIVIDEND_W = 28,
    parameter int DIVISOR_W  = 20,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  qv,
    output logic                  busy,
    output logic                  dbz,
    output logic                  ovf
);

    localparam int N  = DIVIDEND_W;
    localparam int M  = DIVISOR_W;
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam bit SGN = (SIGNED != 0);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   dvd;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [M-1:0]   dvs_mag;
    logic [M-1:0]   prem;
    logic [M-1:0]   dvd_lo;
    logic           q_neg;
    logic           r_neg;
    logic           dbz_r;
    logic           ovf_r;

    logic           dvd_sgn;
    logic           dvs_sgn;
    logic [N-1:0]   dvd_mag_in;
    logic [M-1:0]   dvs_mag_in;
    logic           ovf_in;
    logic [M:0]     trial;
    logic [M:0]     diff;
    logic           take;
    logic [N-1:0]   q_fix;
    logic [M-1:0]   r_fix;
    logic [N-1:0]   q_dbz;

    assign dvd_sgn = SGN && dividend[N-1];
    assign dvs_sgn = SGN && divisor[M-1];
    // Read as unsigned, the negation of the most-negative value is exactly its magnitude.
    assign dvd_mag_in = dvd_sgn ? (~dividend + N'(1)) : dividend;
    assign dvs_mag_in = dvs_sgn ? (~divisor + M'(1)) : divisor;
    assign ovf_in     = SGN && (dividend == MIN_NEG) && (&divisor);

    // prem < dvs_mag keeps trial below 2*dvs_mag, so diff[M] is a clean borrow.
    assign trial = {prem, dvd[N-1]};
    assign diff  = trial - {1'b0, dvs_mag};
    assign take  = ~diff[M] | dbz_r;

    assign q_fix = q_neg ? (~dvd + N'(1)) : dvd;
    assign r_fix = r_neg ? (~prem + M'(1)) : prem;
    assign q_dbz = !SGN ? {N{1'b1}} : (r_neg ? MIN_NEG : ~MIN_NEG);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd       <= '0;
            dvs_mag   <= '0;
            prem      <= '0;
            dvd_lo    <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            dbz_r     <= 1'b0;
            ovf_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            qv        <= 1'b0;
            busy      <= 1'b0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            qv <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd     <= dvd_mag_in;
                        dvs_mag <= dvs_mag_in;
                        dvd_lo  <= dividend[M-1:0];
                        q_neg   <= dvd_sgn ^ dvs_sgn;
                        r_neg   <= dvd_sgn;
                        dbz_r   <= (divisor == '0);
                        ovf_r   <= ovf_in;
                        prem    <= '0;
                        cnt     <= CW'(N - 1);
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    prem <= take ? diff[M-1:0] : trial[M-1:0];
                    dvd  <= {dvd[N-2:0], take};
                    cnt  <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= dbz_r ? q_dbz : q_fix;
                    remainder <= dbz_r ? dvd_lo : r_fix;
                    dbz       <= dbz_r;
                    ovf       <= ovf_r;
                    qv        <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq_qr.sv
// Bench for divider_seq_qr: unsigned and signed instances checked each cycle against an arithmetic model.
module tb_divider_seq_qr;

    logic             clk;
    logic             rst;
    logic [1:0]       start;
    logic [1:0][27:0] dvd;
    logic [1:0][19:0] dvs;
    logic [1:0][27:0] quo;
    logic [1:0][19:0] rem;
    logic [1:0]       qv;
    logic [1:0]       busy;
    logic [1:0]       dbz;
    logic [1:0]       ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 0;

    divider_seq_qr #(.DIVIDEND_W(28), .DIVISOR_W(20), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .start(start[0]), .dividend(dvd[0]), .divisor(dvs[0]),
        .quotient(quo[0]), .remainder(rem[0]), .qv(qv[0]), .busy(busy[0]),
        .dbz(dbz[0]), .ovf(ovf[0])
    );

    divider_seq_qr #(.DIVIDEND_W(28), .DIVISOR_W(20), .SIGNED(1)) s_dut (
        .clk(clk), .rst(rst), .start(start[1]), .dividend(dvd[1]), .divisor(dvs[1]),
        .quotient(quo[1]), .remainder(rem[1]), .qv(qv[1]), .busy(busy[1]),
        .dbz(dbz[1]), .ovf(ovf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint to_l(input logic [63:0] v, input int w, input bit s);
        longint l;
        l = longint'(v);
        if (s && v[w-1]) l = l - (64'sd1 <<< w);
        return l;
    endfunction

    // Reference: plain integer division (SV truncates toward zero) plus the flag rules.
    function automatic void model(input int sgn, input logic [27:0] a, input logic [19:0] b,
                                  output logic [27:0] q, output logic [19:0] r,
                                  output logic dz, output logic ov);
        longint sa, sb, lq, lr;
        sa = to_l({36'd0, a}, 28, sgn != 0);
        sb = to_l({44'd0, b}, 20, sgn != 0);
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            dz = 1'b1;
            r  = a[19:0];
            q  = (sgn == 0) ? 28'hFFFFFFF : (a[27] ? 28'h8000000 : 28'h7FFFFFF);
        end else begin
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[27:0];
            r  = lr[19:0];
            ov = (sgn != 0) && (sa == -134217728) && (sb == -1);
        end
    endfunction

    // Model state per instance: one pending result and the currently held outputs.
    bit          pend[2];
    int          qv_at[2];
    logic [27:0] pq[2], hq[2];
    logic [19:0] pr[2], hr[2];
    logic        pd[2], hd[2], po[2], ho[2];
    longint      pa[2], pb[2], ca[2], cb[2];

    always @(negedge clk) begin
        bit     eq, eb, ok;
        string  p;
        longint qa, ra, absr, absb;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                p  = (i == 0) ? "u" : "s";
                eq = pend[i] && (cyc == qv_at[i]);
                eb = pend[i] && (cyc < qv_at[i]);
                if (eq) begin
                    hq[i] = pq[i]; hr[i] = pr[i]; hd[i] = pd[i]; ho[i] = po[i];
                    ca[i] = pa[i]; cb[i] = pb[i];
                    pend[i] = 1'b0;
                end
                chk({p, ".qv"},        64'(qv[i]),   64'(eq));
                chk({p, ".busy"},      64'(busy[i]), 64'(eb));
                chk({p, ".quotient"},  64'(quo[i]),  64'(hq[i]));
                chk({p, ".remainder"}, 64'(rem[i]),  64'(hr[i]));
                chk({p, ".dbz"},       64'(dbz[i]),  64'(hd[i]));
                chk({p, ".ovf"},       64'(ovf[i]),  64'(ho[i]));
                if (eq && !hd[i] && !ho[i]) begin
                    qa   = to_l({36'd0, quo[i]}, 28, i == 1);
                    ra   = to_l({44'd0, rem[i]}, 20, i == 1);
                    absr = (ra < 0) ? -ra : ra;
                    absb = (cb[i] < 0) ? -cb[i] : cb[i];
                    ok   = (ca[i] == qa * cb[i] + ra) && (absr < absb);
                    chk({p, ".invariant"}, 64'(ok), 64'd1);
                end
                if (rst) begin
                    pend[i] = 1'b0;
                    hq[i] = '0; hr[i] = '0; hd[i] = 1'b0; ho[i] = 1'b0;
                end else if (start[i] && !eb) begin
                    model(i, dvd[i], dvs[i], pq[i], pr[i], pd[i], po[i]);
                    pa[i] = to_l({36'd0, dvd[i]}, 28, i == 1);
                    pb[i] = to_l({44'd0, dvs[i]}, 20, i == 1);
                    pend[i]  = 1'b1;
                    qv_at[i] = cyc + 30;
                end
            end
        end
    end

    task automatic op(input int i, input logic [27:0] a, input logic [19:0] b, output int cs);
        dvd[i]   = a;
        dvs[i]   = b;
        start[i] = 1'b1;
        cs       = cyc;
        @(posedge clk); #1;
        start[i] = 1'b0;
    endtask

    task automatic wait_qv(input int i, output int at, output int bcnt);
        int n;
        at = -1;
        bcnt = 0;
        n = 0;
        while (at < 0 && n < 100) begin
            if (qv[i]) begin
                at = cyc;
            end else begin
                bcnt += int'(busy[i]);
                @(posedge clk); #1;
                n++;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_qv%0d actual=no qv required=qv within 100 cycles", i);
        end
    endtask

    function automatic void rnd(output logic [27:0] a, output logic [19:0] b);
        int k;
        k = $urandom_range(0, 9);
        a = 28'($urandom);
        b = 20'($urandom);
        case (k)
            0: b = '0;
            1: begin a = 28'h8000000; b = 20'hFFFFF; end
            2: b = 20'($urandom_range(1, 15));
            3: b = 20'hFFFFF - 20'($urandom_range(0, 14));
            4: a = 28'($urandom_range(0, 50));
            default: ;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] mq, a;
        logic [19:0] mr, b;
        logic        mdz, mov;
        int          cs, at, bc, cnt;

        rst = 1'b1; start = '0; dvd = '0; dvs = '0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; qv_at[i] = 0; hq[i] = '0; hr[i] = '0; hd[i] = 0; ho[i] = 0;
        end

        // Pin the model against hand-computed results.
        model(0, 28'd1000000, 20'd7, mq, mr, mdz, mov);
        chk("pin_u_q", 64'(mq), 64'd142857);
        chk("pin_u_r", 64'(mr), 64'd1);
        model(0, 28'h0ABCDEF, 20'd0, mq, mr, mdz, mov);
        chk("pin_dbz_q", 64'(mq), 64'hFFFFFFF);
        chk("pin_dbz_r", 64'(mr), 64'hBCDEF);
        model(1, 28'hFFFFF9C, 20'd7, mq, mr, mdz, mov);
        chk("pin_s_q", 64'(mq), 64'hFFFFFF2);
        chk("pin_s_r", 64'(mr), 64'hFFFFE);
        model(1, 28'h8000000, 20'hFFFFF, mq, mr, mdz, mov);
        chk("pin_ovf_q", 64'(mq), 64'h8000000);
        chk("pin_ovf_f", 64'(mov), 64'd1);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_quotient", 64'(quo[0]), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Unsigned basic: latency and busy length.
        op(0, 28'd1000000, 20'd7, cs);
        wait_qv(0, at, bc);
        chk("u_latency", 64'(at - cs), 64'd30);
        chk("u_busy_len", 64'(bc), 64'd29);
        chk("u_q", 64'(quo[0]), 64'd142857);
        chk("u_r", 64'(rem[0]), 64'd1);
        chk("u_dbz", 64'(dbz[0]), 64'd0);

        // Divide by zero.
        op(0, 28'h0ABCDEF, 20'd0, cs);
        wait_qv(0, at, bc);
        chk("dbz_latency", 64'(at - cs), 64'd30);
        chk("dbz_q", 64'(quo[0]), 64'hFFFFFFF);
        chk("dbz_r", 64'(rem[0]), 64'hBCDEF);
        chk("dbz_flag", 64'(dbz[0]), 64'd1);

        // Signed: truncation toward zero, then overflow.
        op(1, 28'hFFFFF9C, 20'd7, cs);
        wait_qv(1, at, bc);
        chk("s_q", 64'(quo[1]), 64'hFFFFFF2);
        chk("s_r", 64'(rem[1]), 64'hFFFFE);
        chk("s_ovf0", 64'(ovf[1]), 64'd0);
        op(1, 28'h8000000, 20'hFFFFF, cs);
        wait_qv(1, at, bc);
        chk("ovf_q", 64'(quo[1]), 64'h8000000);
        chk("ovf_r", 64'(rem[1]), 64'd0);
        chk("ovf_flag", 64'(ovf[1]), 64'd1);

        // Back-to-back start in the qv cycle, plus an ignored mid-operation start.
        op(0, 28'h1234567, 20'h89, cs);
        wait_qv(0, at, bc);
        chk("b2b_first_q", 64'(quo[0]), 64'd139333);
        op(0, 28'hFFFFFFF, 20'hFFFFF, cs);
        repeat (5) @(posedge clk);
        #1;
        op(0, 28'd5, 20'd1, at);
        wait_qv(0, at, bc);
        chk("b2b_latency", 64'(at - cs), 64'd30);
        chk("b2b_q", 64'(quo[0]), 64'h100);
        chk("b2b_r", 64'(rem[0]), 64'hFF);
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            cnt += int'(qv[0]);
        end
        chk("no_extra_qv", 64'(cnt), 64'd0);

        // Reset during CALC aborts the operation.
        op(0, 28'd1000, 20'd3, cs);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_q", 64'(quo[0]), 64'd0);
        chk("abort_busy", 64'(busy[0]), 64'd0);
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            cnt += int'(qv[0]);
            @(posedge clk); #1;
        end
        chk("abort_no_qv", 64'(cnt), 64'd0);
        op(0, 28'd1000, 20'd3, cs);
        wait_qv(0, at, bc);
        chk("post_rst_q", 64'(quo[0]), 64'd333);
        chk("post_rst_r", 64'(rem[0]), 64'd1);

        // Random back-to-back traffic on both instances.
        for (int n = 0; n < 1200; n++) begin
            for (int i = 0; i < 2; i++) begin
                rnd(a, b);
                dvd[i]   = a;
                dvs[i]   = b;
                start[i] = 1'b1;
            end
            @(posedge clk); #1;
            start = '0;
            wait_qv(0, at, bc);
        end

        repeat (40) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
